sccb_cmd_arbiter: RTL
=====================

# sccb_cmd_arbiter

Shares the single SCCB write engine (`i2c_sender`) between two command sources. The first source is the boot-time register ROM sequencer. The second is a runtime write port used by on-chip logic, for example exposure and gain tuning from the CNN/ISP side. Boot commands have absolute priority until the ROM reports end-of-list. Runtime commands are buffered in a small FIFO and issued only after configuration completes. A soft-reset command (COM7 = 0x80) is followed by a programmable settle interval before the next command is issued.

## Interface
- `FIFO_DEPTH`, default 4: runtime command FIFO depth; must be a power of 2, ≥ 2.
- `SETTLE_CYCLES`, default 1_000_000: clk cycles of SCCB silence after a 16'h1280 command is taken; ≥ 1.
- `RST_CMD`, default 16'h1280: command value that triggers the settle interval.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `boot_cmd`  in  16  ROM command: [15:8] register, [7:0] value.
- `boot_end`  in  1  ROM exhausted (ROM output is 16'hFFFF); `boot_cmd` is ignored while this is high.
- `boot_advance`  out  1  one-cycle pulse: ROM steps to the next entry.
- `rt_cmd`  in  16  runtime command.
- `rt_valid`  in  1  runtime write request.
- `rt_ready`  out  1  FIFO not full.
- `snd_send`  out  1  request to the sender.
- `snd_regi`  out  8  register address to the sender.
- `snd_value`  out  8  register value to the sender.
- `snd_taken`  in  1  one-cycle pulse: sender latched regi/value.
- `config_finished`  out  1  boot list fully sent and settled; sticky.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `rt_overflow`  out  1  sticky: `rt_valid` seen while `rt_ready` = 0.

## Operation
- States: IDLE, BOOT, RT, SETTLE.
- **IDLE**
  - If !`boot_end` and !`config_finished`: load `cur_cmd` ← `boot_cmd`; go to BOOT.
  - Else if `config_finished` and FIFO non-empty: load `cur_cmd` ← FIFO head, pop; go to RT.
  - Else, if `boot_end` and !`config_finished`: set `config_finished` next cycle.
- **BOOT / RT**
  - `snd_send` = 1, and `snd_regi`/`snd_value` = `cur_cmd`, held stable until `snd_taken`.
  - On `snd_taken`: go to SETTLE (counter ← `SETTLE_CYCLES` − 1) if `cur_cmd` == `RST_CMD`; else go to IDLE.
- `boot_advance` = `snd_taken` & (state == BOOT), combinational. The ROM updates on the same edge, so IDLE samples the new entry one cycle later.
- **SETTLE**
  - `snd_send` = 0; the counter decrements each cycle.
  - Go to IDLE when the counter reaches 0.
  - Counter width is $clog2(`SETTLE_CYCLES`).
- **FIFO**
  - Push when `rt_valid` & `rt_ready`.
  - `rt_ready` = !full, computed from the registered count. A simultaneous pop does not free a slot in the same cycle.
  - Pointers wrap modulo `FIFO_DEPTH`; the count is `FIFO_DEPTH`+1 values wide.
- Runtime requests are accepted at any time, including during boot. They are held until `config_finished`.
- A runtime `RST_CMD` also triggers SETTLE. `config_finished` stays 1 after it.
- `snd_taken` outside BOOT/RT is ignored.

## Timing
- Reset values:
  - state = IDLE
  - `snd_send` = 0, `snd_regi`/`snd_value` = 0
  - `boot_advance` = 0, `config_finished` = 0, `rt_overflow` = 0, `busy` = 0
  - FIFO empty, so `rt_ready` = 1
- IDLE→send latency: request sampled at edge n, `snd_send` = 1 from cycle n+1.
- After `snd_taken` at cycle t: `snd_send` = 0 in cycle t+1. The earliest next `snd_send` is cycle t+2, so there is at least 1 idle cycle between commands.
- SETTLE from `snd_taken` at t: `snd_send` stays low for `SETTLE_CYCLES` cycles (t+1 … t+`SETTLE_CYCLES`) plus 1 IDLE cycle.
- `config_finished` rises 1 cycle after IDLE observes `boot_end`. It never rises while in SETTLE.
- Reset mid-command: all state is cleared immediately and the FIFO is flushed. The in-flight sender transfer is not tracked.

## Test plan
- **Boot list of 3 entries then `boot_end`, `snd_taken` 5 cycles after each `snd_send` rise**
  - Required: exactly 3 `boot_advance` pulses.
  - Required: regi/value sequence matches the ROM.
  - Required: `config_finished` = 1 two cycles after the third taken.
- **Boot list starting with 16'h1280, `SETTLE_CYCLES` = 20**
  - Required: after the first taken, `snd_send` stays 0 for 21 cycles, then the second entry is sent.
- **4 runtime pushes (0x1000 + k) during boot, 5th push while full**
  - Required: `rt_ready` = 0 after the 4th push; `rt_overflow` = 1.
  - Required: all 4 commands are sent in order only after `config_finished`; the 5th is never sent.
- **Push and pop in the same cycle with FIFO at 3/4**
  - Required: count stays 3, no data loss, order preserved.
- **Assert `rst_n` low during RT with `snd_send` = 1**
  - Required: all outputs at reset values, FIFO empty.
  - Required: after release, the boot list restarts at the ROM's current entry.
- **`snd_taken` pulsed in IDLE and in SETTLE**
  - Required: no state change, no `boot_advance`.

Source files
------------

// File: rtl/sccb_cmd_arbiter_if.sv
// rtl/sccb_cmd_arbiter_if.sv - boot ROM, runtime write port and SCCB sender bundle
//
// Purpose: groups every handshake/bus signal of sccb_cmd_arbiter.
// Ports (slave = arbiter side):
//   boot_cmd/boot_end      in   ROM entry {reg,value} and end-of-list flag
//   boot_advance           out  one-cycle pulse, ROM steps to next entry
//   rt_cmd/rt_valid        in   runtime write request
//   rt_ready               out  runtime FIFO not full
//   snd_send/regi/value    out  request to the SCCB sender
//   snd_taken              in   sender latched regi/value
//   config_finished        out  boot list sent and settled (sticky)
//   busy                   out  arbiter active or FIFO non-empty
//   rt_overflow            out  sticky runtime overflow
interface sccb_cmd_arbiter_if;
    logic [15:0] boot_cmd;
    logic        boot_end;
    logic        boot_advance;
    logic [15:0] rt_cmd;
    logic        rt_valid;
    logic        rt_ready;
    logic        snd_send;
    logic [7:0]  snd_regi;
    logic [7:0]  snd_value;
    logic        snd_taken;
    logic        config_finished;
    logic        busy;
    logic        rt_overflow;

    modport slave (
        input  boot_cmd, boot_end, rt_cmd, rt_valid, snd_taken,
        output boot_advance, rt_ready, snd_send, snd_regi, snd_value,
               config_finished, busy, rt_overflow
    );

    modport master (
        output boot_cmd, boot_end, rt_cmd, rt_valid, snd_taken,
        input  boot_advance, rt_ready, snd_send, snd_regi, snd_value,
               config_finished, busy, rt_overflow
    );
endinterface

// File: rtl/sccb_cmd_arbiter.sv
// rtl/sccb_cmd_arbiter.sv - shares one SCCB write engine between boot ROM and runtime port
//
// Purpose: boot ROM commands go first until end-of-list; runtime commands are
// buffered in a FIFO and issued once configuration is finished. The soft-reset
// command is followed by a silent settle interval.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    sccb_cmd_arbiter_if.slave (boot ROM, runtime port, sender, status)
module sccb_cmd_arbiter #(
    parameter int          FIFO_DEPTH    = 4,
    parameter int          SETTLE_CYCLES = 1_000_000,
    parameter logic [15:0] RST_CMD       = 16'h1280
) (
    input  logic               clk,
    input  logic               rst_n,
    sccb_cmd_arbiter_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    // Keep the counter at least one bit wide so SETTLE_CYCLES = 1 still elaborates.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BOOT, S_RT, S_SETTLE} state_t;

    state_t         r_state;
    logic [15:0]    r_cur_cmd;
    logic           r_snd_send;
    logic           r_cfg_done;
    logic           r_overflow;
    logic [CW-1:0]  r_settle_cnt;

    logic [15:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;

    logic           w_full;
    logic           w_push;
    logic           w_pop;

    // Ready comes from the registered count only: a pop in the same cycle
    // does not make room for a push.
    assign w_full = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_push = bus.rt_valid & ~w_full;
    // IDLE only pops once configuration is done; the boot branch is excluded
    // by that same condition.
    assign w_pop  = (r_state == S_IDLE) & r_cfg_done & (r_count != '0);

    assign bus.rt_ready        = ~w_full;
    assign bus.snd_send        = r_snd_send;
    assign bus.snd_regi        = r_cur_cmd[15:8];
    assign bus.snd_value       = r_cur_cmd[7:0];
    assign bus.boot_advance    = bus.snd_taken & (r_state == S_BOOT);
    assign bus.config_finished = r_cfg_done;
    assign bus.busy            = (r_state != S_IDLE) | (r_count != '0);
    assign bus.rt_overflow     = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rt_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cur_cmd    <= '0;
            r_snd_send   <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_overflow   <= 1'b0;
            r_settle_cnt <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            if (bus.rt_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

            case (r_state)
                S_IDLE: begin
                    if (!bus.boot_end && !r_cfg_done) begin
                        r_cur_cmd  <= bus.boot_cmd;
                        r_snd_send <= 1'b1;
                        r_state    <= S_BOOT;
                    end else if (w_pop) begin
                        r_cur_cmd  <= r_mem[r_rd_ptr];
                        r_snd_send <= 1'b1;
                        r_state    <= S_RT;
                    end else if (!r_cfg_done) begin
                        // Reached only with boot_end high.
                        r_cfg_done <= 1'b1;
                    end
                end
                S_BOOT, S_RT: begin
                    if (bus.snd_taken) begin
                        r_snd_send <= 1'b0;
                        if (r_cur_cmd == RST_CMD) begin
                            r_settle_cnt <= CW'(SETTLE_CYCLES - 1);
                            r_state      <= S_SETTLE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
